mul_sched_ctrl: RTL and testbench
=================================

MUL_SCHED_CTRL -- requirements
Module: mul_sched_ctrl

Interface
REQ-001 SHALL have parameter: M_STAGES, 5, number of multiplier pipeline stages (M1..M5); only 5 is supported.
REQ-002 SHALL have parameter: REG_ADDR_W, 5, register-file address width.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port: issue_valid  in  1  decode presents an instruction for the multiplier.
REQ-006 SHALL have port: issue_aluop  in  5  operation code; only ALUOP_MUL is accepted.
REQ-007 SHALL have port: issue_dst  in  5  destination register of the issued multiply.
REQ-008 SHALL have port: issue_ready  out  1  controller accepts the issue this cycle.
REQ-009 SHALL have port: hold  in  1  global pipeline stall; freezes all stages.
REQ-010 SHALL have port: flush  in  1  kill all in-flight multiplies not yet in M5.
REQ-011 SHALL have port: alu_wb_req  in  1  ALU wants the shared register-file write port this cycle.
REQ-012 SHALL have port: alu_wb_stall  out  1  ALU denied the write port this cycle.
REQ-013 SHALL have port: stage_en  out  5  load enable for M1..M5 datapath registers (bit0 = M1).
REQ-014 SHALL have port: stage_valid  out  5  valid bit per stage.
REQ-015 SHALL have port: wb_valid  out  1  M5 result is written back this cycle.
REQ-016 SHALL have port: wb_dst  out  5  writeback destination register.
REQ-017 SHALL have port: busy_mask  out  32  registers with a multiply in flight (bit0 always 0).
REQ-018 SHALL have port: occupancy  out  3  number of valid stages, 0..5.

Function
REQ-019 Accept SHALL occur when issue_valid & issue_ready; a non-MUL issue_aluop SHALL deassert issue_ready and change no state.
REQ-020 issue_ready SHALL be high only when issue_aluop==ALUOP_MUL, ~hold, ~flush, and busy_mask[issue_dst]==0 (WAW block, including a dst retiring from M5 this cycle).
REQ-021 When ~hold, each edge SHALL shift valid/dst M1->M2->...->M5; M1 SHALL load the accept bit and issue_dst; the M5 entry SHALL retire.
REQ-022 When hold=1, all stage_valid/dst SHALL hold; stage_en SHALL be 0; wb_valid SHALL be 0; issue_ready SHALL be 0.
REQ-023 stage_en[i] SHALL equal ~hold & (valid entering stage i); an empty bubble SHALL NOT enable its stage.
REQ-024 Latency: a multiply accepted in cycle t SHALL have stage_valid[4]=1 and wb_valid=1 in cycle t+5, absent hold/flush.
REQ-025 wb_valid SHALL be stage_valid[4] & ~hold & (M5 dst != 0); wb_dst SHALL be the M5 dst (combinational).
REQ-026 alu_wb_stall SHALL be alu_wb_req & wb_valid; the multiplier always wins the write port.
REQ-027 busy_mask SHALL be the OR of one-hot decodes of every valid stage's dst, excluding register 0.
REQ-028 flush (with ~hold) SHALL clear M1..M4 valid on the next edge; the M5 entry SHALL still retire; no accept that cycle.
REQ-029 flush with hold SHALL clear M1..M4 and keep M5 frozen.
REQ-030 occupancy SHALL equal popcount(stage_valid); max 5 (one issue per cycle).

Reset
REQ-031 rst_n low SHALL asynchronously clear all stage_valid and stage dst registers to 0.
REQ-032 During and after reset: issue_ready follows REQ-020, wb_valid=0, alu_wb_stall=0, busy_mask=0, occupancy=0, stage_en=0 except the accept path.
REQ-033 Reset mid-operation SHALL discard all in-flight multiplies with no writeback.

Structure
REQ-034 ALUOP_MUL, REG_SIZE and the stage count SHALL come from the shared define.v; no local redefinition.
REQ-035 One sub-module, mul_stage_tag (valid + dst flop with enable, async clear), SHALL be instantiated per stage.

Verification
REQ-036 Single MUL dst=7 at t=0 -> stage_valid walks 00001..10000, wb_valid=1 with wb_dst=7 at t=5, busy_mask[7] high t=1..t=5.
REQ-037 Back-to-back MULs dst=1..5 -> occupancy reaches 5, one writeback per cycle t=5..9 in order.
REQ-038 MUL dst=3 in flight, second MUL dst=3 -> issue_ready=0 until the cycle after first writeback; dst=4 accepted immediately.
REQ-039 hold=1 for 3 cycles with M3 valid -> stage_en=0, state frozen, writeback delayed exactly 3 cycles.
REQ-040 flush with M2 and M5 valid -> M5 writes back, M2 gone, busy_mask cleared for the M2 dst next cycle.
REQ-041 alu_wb_req=1 when M5 dst=9 valid -> alu_wb_stall=1; MUL with dst=0 -> wb_valid=0, alu_wb_stall=0.

Source files
------------

// File: rtl/mul_sched_ctrl_pkg.sv
// Shared constants for the multiplier scheduling controller: op codes,
// register-file size, pipeline depth and a small popcount helper.
package mul_sched_ctrl_pkg;

    localparam int         REG_SIZE   = 32;
    localparam int         MUL_STAGES = 5;
    localparam logic [4:0] ALUOP_MUL  = 5'b01010;

    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < 5; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mul_stage_tag.sv
// One multiplier pipeline stage tag: valid bit plus destination register,
// with shift/advance, data load enable and a kill input.
module mul_stage_tag
    import mul_sched_ctrl_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         valid_i,
    input  logic [W-1:0] dst_i,
    output logic         valid_o,
    output logic [W-1:0] dst_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] dst_q, dst_d;

    // A kill wins over everything; bubbles still shift the valid bit but
    // leave the destination untouched since the stage is not enabled.
    always_comb begin
        valid_d = valid_q;
        dst_d   = dst_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (adv_i) begin
            valid_d = valid_i;
        end
        if (en_i) begin
            dst_d = dst_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dst_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
        end
    end

    assign valid_o = valid_q;
    assign dst_o   = dst_q;

endmodule

// File: rtl/mul_sched_ctrl.sv
// Issue, stall, flush and writeback-arbitration control for the 5-stage
// multiplier pipeline; tracks in-flight destinations for WAW blocking.
module mul_sched_ctrl
    import mul_sched_ctrl_pkg::*;
#(
    parameter int M_STAGES   = MUL_STAGES,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_aluop,
    input  logic [REG_ADDR_W-1:0] issue_dst,
    output logic                  issue_ready,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  alu_wb_req,
    output logic                  alu_wb_stall,
    output logic [M_STAGES-1:0]   stage_en,
    output logic [M_STAGES-1:0]   stage_valid,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic [REG_SIZE-1:0]   busy_mask,
    output logic [2:0]            occupancy
);

    logic [M_STAGES-1:0]   vin;
    logic [M_STAGES-1:0]   valid;
    logic [REG_ADDR_W-1:0] dst_q [M_STAGES];
    logic                  accept;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < M_STAGES; i++) begin
            if (valid[i] && (dst_q[i] != '0)) begin
                busy_mask[dst_q[i]] = 1'b1;
            end
        end
    end

    // busy_mask covers M5 too, so a dst retiring this cycle still blocks.
    assign issue_ready = (issue_aluop == ALUOP_MUL) & ~hold & ~flush
                       & ~busy_mask[issue_dst];
    assign accept      = issue_valid & issue_ready;

    always_comb begin
        vin    = '0;
        vin[0] = accept;
        for (int i = 1; i < M_STAGES; i++) begin
            vin[i] = valid[i-1] & ~flush;
        end
    end

    assign stage_en = {M_STAGES{~hold}} & vin;

    for (genvar g = 0; g < M_STAGES; g++) begin : g_stage
        logic [REG_ADDR_W-1:0] dst_in;
        logic                  kill;

        if (g == 0) begin : g_head
            assign dst_in = issue_dst;
        end else begin : g_body
            assign dst_in = dst_q[g-1];
        end

        // M5 is never killed: it either retires or stays frozen under hold.
        assign kill = (g < M_STAGES - 1) ? flush : 1'b0;

        mul_stage_tag #(
            .W (REG_ADDR_W)
        ) u_tag (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv_i   (~hold),
            .en_i    (stage_en[g]),
            .clr_i   (kill),
            .valid_i (vin[g]),
            .dst_i   (dst_in),
            .valid_o (valid[g]),
            .dst_o   (dst_q[g])
        );
    end

    assign stage_valid  = valid;
    assign wb_dst       = dst_q[M_STAGES-1];
    assign wb_valid     = valid[M_STAGES-1] & ~hold & (dst_q[M_STAGES-1] != '0);
    assign alu_wb_stall = alu_wb_req & wb_valid;
    assign occupancy    = popcount5(valid);

endmodule

// File: tb/tb_mul_sched_ctrl.sv
// Randomized bench for mul_sched_ctrl against a queue-based model of the
// in-flight multiplies (each op tracked by destination and pipeline age).
module tb_mul_sched_ctrl;
    import mul_sched_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_aluop = ALUOP_MUL;
    logic [4:0]  issue_dst = '0;
    logic        issue_ready;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        alu_wb_req = 1'b0;
    logic        alu_wb_stall;
    logic [4:0]  stage_en;
    logic [4:0]  stage_valid;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [31:0] busy_mask;
    logic [2:0]  occupancy;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int dst;
        int age;
    } op_t;
    op_t ops[$];

    mul_sched_ctrl #(
        .M_STAGES   (5),
        .REG_ADDR_W (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_aluop  (issue_aluop),
        .issue_dst    (issue_dst),
        .issue_ready  (issue_ready),
        .hold         (hold),
        .flush        (flush),
        .alu_wb_req   (alu_wb_req),
        .alu_wb_stall (alu_wb_stall),
        .stage_en     (stage_en),
        .stage_valid  (stage_valid),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .busy_mask    (busy_mask),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check combinational
    // outputs against the model, then advance the model to the next edge.
    task automatic step(input bit v, input logic [4:0] op, input logic [4:0] d,
                        input bit h, input bit f, input bit req);
        logic [31:0] e_busy;
        logic [4:0]  e_sv, e_en;
        bit          e_rdy, e_acc, e_wb;
        int          m5_dst, cnt;
        op_t         nq[$];

        @(negedge clk);
        issue_valid = v;
        issue_aluop = op;
        issue_dst   = d;
        hold        = h;
        flush       = f;
        alu_wb_req  = req;
        #1;

        e_busy = '0;
        e_sv   = '0;
        m5_dst = -1;
        foreach (ops[k]) begin
            e_sv[ops[k].age] = 1'b1;
            if (ops[k].dst != 0) e_busy[ops[k].dst] = 1'b1;
            if (ops[k].age == 4) m5_dst = ops[k].dst;
        end
        cnt   = ops.size();
        e_rdy = (op == ALUOP_MUL) && !h && !f && !e_busy[d];
        e_acc = v && e_rdy;
        e_en  = '0;
        if (!h) begin
            e_en[0] = e_acc;
            for (int s = 1; s < 5; s++) e_en[s] = e_sv[s-1] && !f;
        end
        e_wb = (m5_dst >= 0) && !h && (m5_dst != 0);

        chk("issue_ready", 32'(issue_ready), 32'(e_rdy));
        chk("stage_en", 32'(stage_en), 32'(e_en));
        chk("stage_valid", 32'(stage_valid), 32'(e_sv));
        chk("wb_valid", 32'(wb_valid), 32'(e_wb));
        if (m5_dst >= 0) chk("wb_dst", 32'(wb_dst), 32'(m5_dst));
        chk("alu_wb_stall", 32'(alu_wb_stall), 32'(req && e_wb));
        chk("busy_mask", busy_mask, e_busy);
        chk("occupancy", 32'(occupancy), 32'(cnt));

        nq = {};
        foreach (ops[k]) begin
            if (h) begin
                if (!(f && ops[k].age < 4)) nq.push_back(ops[k]);
            end else if (ops[k].age < 4 && !f) begin
                nq.push_back('{dst: ops[k].dst, age: ops[k].age + 1});
            end
        end
        if (e_acc) nq.push_back('{dst: int'(d), age: 0});
        ops = nq;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, ALUOP_MUL, 5'd0, 0, 0, 0);
    endtask

    task automatic mul(input logic [4:0] d);
        step(1, ALUOP_MUL, d, 0, 0, 0);
    endtask

    // Asynchronous reset with a MUL presented: only the accept path may
    // show activity; all state is empty and stays empty across an edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        issue_valid = 1'b1;
        issue_aluop = ALUOP_MUL;
        issue_dst   = 5'd5;
        hold        = 1'b0;
        flush       = 1'b0;
        alu_wb_req  = 1'b1;
        #1;
        chk("rst_stage_valid", 32'(stage_valid), 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_alu_stall", 32'(alu_wb_stall), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_stage_en", 32'(stage_en), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(stage_valid), 32'd0);
        issue_valid = 1'b0;
        alu_wb_req  = 1'b0;
        rst_n       = 1'b1;
        ops.delete();
    endtask

    initial begin
        do_reset();

        mul(5'd7);
        idle(7);

        for (int i = 1; i <= 5; i++) mul(5'(i));
        idle(6);

        mul(5'd3);
        mul(5'd3);
        mul(5'd4);
        for (int i = 0; i < 6; i++) mul(5'd3);
        idle(6);

        mul(5'd6);
        idle(2);
        for (int i = 0; i < 3; i++) step(0, ALUOP_MUL, 5'd0, 1, 0, 0);
        idle(5);

        mul(5'd10);
        idle(2);
        mul(5'd11);
        idle(1);
        step(0, ALUOP_MUL, 5'd0, 0, 1, 0);
        idle(5);

        mul(5'd12);
        mul(5'd13);
        idle(2);
        step(0, ALUOP_MUL, 5'd0, 1, 1, 0);
        idle(5);

        step(1, ALUOP_MUL, 5'd9, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, ALUOP_MUL, 5'd0, 0, 0, 1);
        step(1, ALUOP_MUL, 5'd0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, ALUOP_MUL, 5'd0, 0, 0, 1);

        step(1, 5'b00001, 5'd8, 0, 0, 0);
        idle(1);

        mul(5'd14);
        mul(5'd15);
        do_reset();
        idle(6);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] op;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ALUOP_MUL;
                step(bit'($urandom_range(0, 3) != 0), op, 5'($urandom_range(0, 9)),
                     bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 11) == 0),
                     bit'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
